instruction_fetch: RTL and testbench

- Instruction-fetch stage of the SPU pipeline; generates word addresses into local instruction storage and pulls one 16-instruction line per request.
- Buffers the line and issues it to decode as 8 consecutive even/odd instruction pairs, one pair per cycle, for dual issue.
- Sits between the instruction memory model/local store and the decode stage.

---
 rtl/spu_if_pkg.sv | 19 +
 rtl/if_line_buffer.sv | 32 +++
 rtl/instruction_fetch.sv | 128 ++++++++++++
 tb/tb_instruction_fetch.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spu_if_pkg.sv
// Shared constants and state encoding for the SPU instruction-fetch stage.
package spu_if_pkg;

    localparam int unsigned INSTR_W    = 32;
    localparam int unsigned MEM_WORDS  = 256;
    localparam int unsigned LINE_WORDS = 16;
    localparam int unsigned PC_W       = 8;

    // A line is issued as even/odd pairs; PAIR_W indexes the pair within a line.
    localparam int unsigned PAIRS  = LINE_WORDS / 2;
    localparam int unsigned PAIR_W = $clog2(PAIRS);

    typedef enum logic [1:0] {
        REQ,
        LOAD,
        ISSUE
    } if_state_t;

endpackage

// File: rtl/if_line_buffer.sv
// Holds one fetched instruction line and presents the even/odd pair selected by k.
module if_line_buffer
    import spu_if_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [0:INSTR_W-1] line_in [0:LINE_WORDS-1],
    input  logic [PAIR_W-1:0]  k,
    output logic [0:INSTR_W-1] even,
    output logic [0:INSTR_W-1] odd
);

    logic [0:INSTR_W-1] line_q [0:LINE_WORDS-1];

    // Capture the whole line on the load strobe; reset discards any buffered line.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(LINE_WORDS); i++) begin
                line_q[i] <= '0;
            end
        end else if (load) begin
            for (int i = 0; i < int'(LINE_WORDS); i++) begin
                line_q[i] <= line_in[i];
            end
        end
    end

    assign even = line_q[{k, 1'b0}];
    assign odd  = line_q[{k, 1'b1}];

endmodule

// File: rtl/instruction_fetch.sv
// SPU instruction-fetch stage: requests a 16-instruction line from local store,
// buffers it, and issues it to decode as 8 consecutive even/odd pairs.
// Optional macro IF_TRACE_EN adds simulation-only trace of requests and issues.
module instruction_fetch
    import spu_if_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [0:INSTR_W-1] instr [0:MEM_WORDS-1],
    output logic [PC_W-1:0]    pc,
    output logic               read_enable,
    output logic [0:INSTR_W-1] instr_even,
    output logic [0:INSTR_W-1] instr_odd,
    output logic [PC_W-1:0]    issue_pc,
    output logic               issue_valid
);

    if_state_t          state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [PAIR_W-1:0]  k_q, k_d;
    logic               armed_q;
    logic               load;

    logic [0:INSTR_W-1] line [0:LINE_WORDS-1];
    logic [0:INSTR_W-1] pair_even, pair_odd;
    logic [PC_W-1:0]    pair_pc;
    logic [0:INSTR_W-1] last_even_q, last_odd_q;
    logic [PC_W-1:0]    last_pc_q;

    // Only the first LINE_WORDS entries carry the requested line.
    always_comb begin
        for (int i = 0; i < int'(LINE_WORDS); i++) begin
            line[i] = instr[i];
        end
    end

    if_line_buffer u_line_buffer (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .line_in (line),
        .k       (k_q),
        .even    (pair_even),
        .odd     (pair_odd)
    );

    // Next-state logic: one REQ cycle, one LOAD cycle, then PAIRS issue cycles.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        k_d     = k_q;
        load    = 1'b0;
        unique case (state_q)
            REQ: begin
                // Hold off the first request until one edge after reset release.
                if (armed_q) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                load    = 1'b1;
                k_d     = '0;
                state_d = ISSUE;
            end
            ISSUE: begin
                if (k_q == PAIR_W'(PAIRS - 1)) begin
                    k_d     = '0;
                    pc_d    = pc_q + PC_W'(LINE_WORDS);
                    state_d = REQ;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            default: state_d = REQ;
        endcase
    end

    // State, line address and pair index registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= REQ;
            pc_q    <= '0;
            k_q     <= '0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            k_q     <= k_d;
            armed_q <= 1'b1;
        end
    end

    assign pair_pc = pc_q + PC_W'({k_q, 1'b0});

    // Remember the last issued pair so the outputs hold outside ISSUE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_even_q <= '0;
            last_odd_q  <= '0;
            last_pc_q   <= '0;
        end else if (state_q == ISSUE) begin
            last_even_q <= pair_even;
            last_odd_q  <= pair_odd;
            last_pc_q   <= pair_pc;
        end
    end

    assign pc          = pc_q;
    assign read_enable = (state_q == REQ) && armed_q;
    assign issue_valid = (state_q == ISSUE);
    assign instr_even  = issue_valid ? pair_even : last_even_q;
    assign instr_odd   = issue_valid ? pair_odd  : last_odd_q;
    assign issue_pc    = issue_valid ? pair_pc   : last_pc_q;

`ifdef IF_TRACE_EN
    // Simulation-only trace of line requests and issued pairs.
    always @(posedge clk) begin
        if (reset && read_enable) begin
            $display("%0t if: REQ pc=%0d", $time, pc);
        end
        if (reset && issue_valid) begin
            $display("%0t if: ISSUE pc=%0d even=%h odd=%h", $time, issue_pc, instr_even,
                     instr_odd);
        end
    end
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: a memory model answers each request,
// pushing the expected pairs to a scoreboard that the scenario tasks pop and compare.
module tb_instruction_fetch;

    logic        clk;
    logic        reset;
    logic [0:31] instr [0:255];
    logic [7:0]  pc;
    logic        read_enable;
    logic [0:31] instr_even;
    logic [0:31] instr_odd;
    logic [7:0]  issue_pc;
    logic        issue_valid;

    typedef struct {
        logic [0:31] even;
        logic [0:31] odd;
        logic [7:0]  pc;
    } pair_t;

    pair_t sb[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    cyc      = 0;
    int    re_cyc   = 0;
    logic  scramble = 1'b0;

    instruction_fetch dut (
        .clk         (clk),
        .reset       (reset),
        .instr       (instr),
        .pc          (pc),
        .read_enable (read_enable),
        .instr_even  (instr_even),
        .instr_odd   (instr_odd),
        .issue_pc    (issue_pc),
        .issue_valid (issue_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [0:31] word(input int line_pc, input int i);
        return 32'h1000_0000 + line_pc + i;
    endfunction

    // Memory side: load the line on the request edge; optionally trash it while issuing.
    initial begin
        for (int i = 0; i < 256; i++) instr[i] <= '0;
    end

    always @(posedge clk) begin
        if (reset && read_enable) begin
            for (int i = 0; i < 16; i++) instr[i] <= word(int'(pc), i);
            for (int k = 0; k < 8; k++) begin
                pair_t p;
                p.even = word(int'(pc), 2 * k);
                p.odd  = word(int'(pc), 2 * k + 1);
                p.pc   = pc + 8'(2 * k);
                sb.push_back(p);
            end
        end else if (reset && scramble && issue_valid) begin
            for (int i = 0; i < 16; i++) instr[i] <= $urandom;
        end
    end

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (pc !== 8'd0 || read_enable !== 1'b0 || issue_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: pc=%0d re=%b iv=%b required pc=0 re=0 iv=0",
                     pc, read_enable, issue_valid);
        end
        n_checks++;
        if (instr_even !== 32'd0 || instr_odd !== 32'd0 || issue_pc !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_pair: even=%h odd=%h ipc=%0d required all zero",
                     instr_even, instr_odd, issue_pc);
        end
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if (read_enable !== 1'b1 || pc !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_first_req: re=%b pc=%0d required re=1 pc=0", read_enable, pc);
        end
        re_cyc = cyc;
    endtask

    // Entered on the REQ cycle of line 0.
    task automatic test_first_line();
        @(negedge clk);
        n_checks++;
        if (read_enable !== 1'b0 || issue_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL first_load: re=%b iv=%b required 0 0", read_enable, issue_valid);
        end
        for (int k = 0; k < 8; k++) begin
            pair_t p;
            @(negedge clk);
            n_checks++;
            if (issue_valid !== 1'b1 || sb.size() == 0) begin
                n_fail++;
                $display("FAIL first_valid k=%0d: iv=%b queued=%0d required iv=1", k,
                         issue_valid, sb.size());
            end else begin
                p = sb.pop_front();
                n_checks++;
                if (instr_even !== p.even || instr_odd !== p.odd || issue_pc !== p.pc) begin
                    n_fail++;
                    $display("FAIL first_pair k=%0d: got %h %h pc=%0d required %h %h pc=%0d",
                             k, instr_even, instr_odd, issue_pc, p.even, p.odd, p.pc);
                end
            end
        end
    endtask

    task automatic test_second_line();
        @(negedge clk);
        n_checks++;
        if (read_enable !== 1'b1 || pc !== 8'd16 || cyc - re_cyc != 10) begin
            n_fail++;
            $display("FAIL second_req: re=%b pc=%0d spacing=%0d required re=1 pc=16 spacing=10",
                     read_enable, pc, cyc - re_cyc);
        end
        re_cyc = cyc;
        @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            pair_t p;
            @(negedge clk);
            n_checks++;
            if (issue_valid !== 1'b1 || sb.size() == 0) begin
                n_fail++;
                $display("FAIL second_valid k=%0d: iv=%b required 1", k, issue_valid);
            end else begin
                p = sb.pop_front();
                n_checks++;
                if (instr_even !== p.even || instr_odd !== p.odd ||
                    issue_pc !== 8'(16 + 2 * k)) begin
                    n_fail++;
                    $display("FAIL second_pair k=%0d: got %h %h pc=%0d required %h %h pc=%0d",
                             k, instr_even, instr_odd, issue_pc, p.even, p.odd, 16 + 2 * k);
                end
            end
        end
    endtask

    task automatic test_wrap();
        for (int line = 2; line < 16; line++) begin
            @(negedge clk);
            n_checks++;
            if (read_enable !== 1'b1 || pc !== 8'(line * 16) || cyc - re_cyc != 10) begin
                n_fail++;
                $display("FAIL wrap_req line=%0d: re=%b pc=%0d spacing=%0d required pc=%0d",
                         line, read_enable, pc, cyc - re_cyc, line * 16);
            end
            re_cyc = cyc;
            @(negedge clk);
            for (int k = 0; k < 8; k++) begin
                pair_t p;
                @(negedge clk);
                if (sb.size() != 0) begin
                    p = sb.pop_front();
                    n_checks++;
                    if (issue_valid !== 1'b1 || instr_even !== p.even || instr_odd !== p.odd ||
                        issue_pc !== p.pc) begin
                        n_fail++;
                        $display("FAIL wrap_pair line=%0d k=%0d: iv=%b %h %h pc=%0d required %h %h pc=%0d",
                                 line, k, issue_valid, instr_even, instr_odd, issue_pc,
                                 p.even, p.odd, p.pc);
                    end
                end else begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL wrap_queue line=%0d k=%0d: queue empty required entry", line, k);
                end
            end
        end
        @(negedge clk);
        n_checks++;
        if (read_enable !== 1'b1 || pc !== 8'd0) begin
            n_fail++;
            $display("FAIL wrap_to_zero: re=%b pc=%0d required re=1 pc=0", read_enable, pc);
        end
    endtask

    // Entered on the REQ cycle of the line at pc=0.
    task automatic test_isolation();
        scramble = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            pair_t p;
            @(negedge clk);
            if (sb.size() != 0) begin
                p = sb.pop_front();
                n_checks++;
                if (issue_valid !== 1'b1 || instr_even !== p.even || instr_odd !== p.odd ||
                    instr_even !== 32'h1000_0000 + 32'(2 * k)) begin
                    n_fail++;
                    $display("FAIL isolation k=%0d: iv=%b %h %h required %h %h", k, issue_valid,
                             instr_even, instr_odd, p.even, p.odd);
                end
            end else begin
                n_checks++;
                n_fail++;
                $display("FAIL isolation_queue k=%0d: queue empty required entry", k);
            end
        end
        scramble = 1'b0;
        @(negedge clk);
    endtask

    // Entered on the REQ cycle of the line at pc=16.
    task automatic test_reset_mid();
        @(negedge clk);
        repeat (4) @(negedge clk);
        n_checks++;
        if (issue_valid !== 1'b1 || issue_pc !== 8'd22) begin
            n_fail++;
            $display("FAIL mid_k3: iv=%b ipc=%0d required iv=1 ipc=22", issue_valid, issue_pc);
        end
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if (issue_valid !== 1'b0 || read_enable !== 1'b0 || pc !== 8'd0 ||
            instr_even !== 32'd0 || instr_odd !== 32'd0 || issue_pc !== 8'd0) begin
            n_fail++;
            $display("FAIL mid_async_clear: iv=%b re=%b pc=%0d %h %h ipc=%0d required all zero",
                     issue_valid, read_enable, pc, instr_even, instr_odd, issue_pc);
        end
        sb.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if (read_enable !== 1'b1 || pc !== 8'd0) begin
            n_fail++;
            $display("FAIL mid_restart: re=%b pc=%0d required re=1 pc=0", read_enable, pc);
        end
        @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            pair_t p;
            @(negedge clk);
            if (sb.size() != 0) begin
                p = sb.pop_front();
                n_checks++;
                if (issue_valid !== 1'b1 || instr_even !== p.even || instr_odd !== p.odd ||
                    issue_pc !== 8'(2 * k)) begin
                    n_fail++;
                    $display("FAIL mid_pair k=%0d: iv=%b %h %h pc=%0d required %h %h pc=%0d",
                             k, issue_valid, instr_even, instr_odd, issue_pc, p.even, p.odd,
                             2 * k);
                end
            end else begin
                n_checks++;
                n_fail++;
                $display("FAIL mid_queue k=%0d: queue empty required entry", k);
            end
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL mid_leftover: queued=%0d required 0", sb.size());
        end
    endtask

    initial begin
        reset = 1'b0;
        @(negedge clk);
        test_reset();
        test_first_line();
        test_second_line();
        test_wrap();
        test_isolation();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
